// File: rtl/rs_pkg.sv
// Shared Reed-Solomon constants: field polynomial, default geometry, FSM states
// and the alpha^j constant table used by the syndrome cells.
package rs_pkg;

    localparam int M_DEF = 8;
    localparam int N_DEF = 255;
    localparam int T_DEF = 8;

    localparam logic [8:0] PRIM_POLY = 9'h11D;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    function automatic logic [7:0] alpha_pow(input int k);
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < k; i++) begin
            x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
        end
        return x;
    endfunction

    function automatic logic [2*T_DEF*M_DEF-1:0] alpha_tab();
        logic [2*T_DEF*M_DEF-1:0] tab;
        tab = '0;
        for (int j = 1; j <= 2*T_DEF; j++) begin
            tab[j*M_DEF-1 -: M_DEF] = alpha_pow(j);
        end
        return tab;
    endfunction

    // alpha^j lives at bits [j*M-1 -: M], matching the synd bus layout
    localparam logic [2*T_DEF*M_DEF-1:0] ALPHA_TAB = alpha_tab();

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Symbol input and syndrome output handshakes of rs_syndrome_calc.
// synd_nonzero exists only when RS_SYND_FLAG_EN is defined.
interface rs_syndrome_calc_if
    import rs_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int T = T_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [M-1:0]     in_data;
    logic             synd_valid;
    logic             synd_ready;
    logic [2*T*M-1:0] synd;
`ifdef RS_SYND_FLAG_EN
    logic             synd_nonzero;

    modport master (
        output in_valid, in_data, synd_ready,
        input  in_ready, synd_valid, synd, synd_nonzero
    );

    modport slave (
        input  in_valid, in_data, synd_ready,
        output in_ready, synd_valid, synd, synd_nonzero
    );
`else
    modport master (
        output in_valid, in_data, synd_ready,
        input  in_ready, synd_valid, synd
    );

    modport slave (
        input  in_valid, in_data, synd_ready,
        output in_ready, synd_valid, synd
    );
`endif

endinterface

// File: rtl/gf_multiplier_comb.sv
// Combinational GF(2^M) multiplier; a constant operand folds away in synthesis.
module gf_multiplier_comb #(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h11D
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic [M-1:0] p_o
);

    always_comb begin
        logic [M-1:0] sh;
        p_o = '0;
        sh  = a_i;
        for (int i = 0; i < M; i++) begin
            if (b_i[i]) p_o = p_o ^ sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY[M-1:0] : '0);
        end
    end

endmodule

// File: rtl/rs_synd_cell.sv
// One Horner cell: S <= S * alpha^j ^ symbol on accept, cleared on handshake.
module rs_synd_cell
    import rs_pkg::*;
#(
    parameter int           M       = 8,
    parameter logic [M-1:0] ALPHA_J = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         acc_i,
    input  logic         clr_i,
    input  logic [M-1:0] din_i,
    output logic [M-1:0] s_o,
    output logic [M-1:0] s_d_o
);

    logic [M-1:0] s_q;
    logic [M-1:0] s_d;
    logic [M-1:0] prod;

    gf_multiplier_comb #(
        .M    (M),
        .POLY ((M+1)'(PRIM_POLY))
    ) u_mul (
        .a_i (s_q),
        .b_i (ALPHA_J),
        .p_o (prod)
    );

    always_comb begin
        s_d = s_q;
        if (clr_i)      s_d = '0;
        else if (acc_i) s_d = prod ^ din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= '0;
        else        s_q <= s_d;
    end

    assign s_o   = s_q;
    assign s_d_o = s_d;

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS syndrome calculator: 2T parallel Horner cells, block counter and ACCUM/DONE FSM.
// Optional registered synd_nonzero flag via `define RS_SYND_FLAG_EN.
module rs_syndrome_calc
    import rs_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF,
    parameter int T = T_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rs_syndrome_calc_if.slave        bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             accept;
    logic             clr;
    logic [2*T*M-1:0] synd_q;
    logic [2*T*M-1:0] synd_d;

    assign accept = bus.in_valid && (state_q == ACCUM);
    assign clr    = bus.synd_ready && (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == CW'(N-1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.synd_ready) state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar j = 1; j <= 2*T; j++) begin : g_cell
        rs_synd_cell #(
            .M       (M),
            .ALPHA_J (M'(alpha_pow(j)))
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .acc_i (accept),
            .clr_i (clr),
            .din_i (bus.in_data),
            .s_o   (synd_q[j*M-1 -: M]),
            .s_d_o (synd_d[j*M-1 -: M])
        );
    end

    assign bus.in_ready   = (state_q == ACCUM);
    assign bus.synd_valid = (state_q == DONE);
    assign bus.synd       = synd_q;

`ifdef RS_SYND_FLAG_EN
    // Reduced from next-state so the flag lands on the same edge as S_j
    logic nz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) nz_q <= 1'b0;
        else        nz_q <= |synd_d;
    end

    assign bus.synd_nonzero = nz_q;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed + random bench for rs_syndrome_calc against a polynomial-evaluation model.
module tb_rs_syndrome_calc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] sym [0:509];
    int exp_t [0:254];
    int log_t [0:255];

    rs_syndrome_calc_if #(.M(8), .T(8)) bus ();

    rs_syndrome_calc #(
        .M (8),
        .N (255),
        .T (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // S_j = sum over degrees i of r_i * alpha^(i*j); sym[off] is r(254)
    function automatic logic [127:0] model(input int off);
        logic [127:0] v;
        int s;
        v = '0;
        for (int j = 1; j <= 16; j++) begin
            s = 0;
            for (int k = 0; k < 255; k++) begin
                s = s ^ gmul(int'(sym[off+k]), exp_t[((254 - k) * j) % 255]);
            end
            v[j*8-1 -: 8] = 8'(s);
        end
        return v;
    endfunction

    task automatic send(input int off, input int cnt, input int gap, output logic sv_pre);
        logic v;
        logic rdy;
        int idx;
        int cyc;
        idx    = 0;
        cyc    = 0;
        sv_pre = 1'b0;
        while (idx < cnt && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            v = ($urandom_range(99) >= gap);
            bus.in_valid = v;
            bus.in_data  = v ? sym[off+idx] : 8'($urandom);
            rdy = bus.in_ready;
            if (idx == cnt - 1) sv_pre = bus.synd_valid;
            @(posedge clk);
            if (v && rdy) idx++;
        end
        chk("send_done", 128'(idx), 128'(cnt));
    endtask

    task automatic hs();
        bus.synd_ready = 1'b1;
        @(negedge clk);
        bus.synd_ready = 1'b0;
        chk("hs_valid", 128'(bus.synd_valid), 128'(0));
        chk("hs_clear", bus.synd, 128'(0));
        chk("hs_ready", 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        logic sv;
        logic [127:0] snap;
        logic [127:0] ea;
        logic [127:0] eb;
        int x;
        int idx;
        int cyc;
        int nb;
        int idle;
        logic v;
        logic rdy;

        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 285;
        end
        log_t[0] = 0;

        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.synd_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(bus.synd_valid), 128'(0));
        chk("rst_synd", bus.synd, 128'(0));
`ifdef RS_SYND_FLAG_EN
        chk("rst_nz", 128'(bus.synd_nonzero), 128'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(bus.in_ready), 128'(1));

        for (int i = 0; i < 510; i++) sym[i] = 8'h00;
        send(0, 255, 0, sv);
        chk("zero_lat_pre", 128'(sv), 128'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("zero_lat_valid", 128'(bus.synd_valid), 128'(1));
        chk("zero_ready", 128'(bus.in_ready), 128'(0));
        chk("zero_synd", bus.synd, 128'(0));
        chk("zero_model", bus.synd, model(0));
`ifdef RS_SYND_FLAG_EN
        chk("zero_nz", 128'(bus.synd_nonzero), 128'(0));
`endif
        hs();

        sym[254] = 8'h05;
        send(0, 255, 0, sv);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("r0_const", bus.synd, {16{8'h05}});
        chk("r0_model", bus.synd, model(0));
`ifdef RS_SYND_FLAG_EN
        chk("r0_nz", 128'(bus.synd_nonzero), 128'(1));
`endif
        hs();

        sym[254] = 8'h00;
        sym[0]   = 8'h01;
        send(0, 255, 0, sv);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("r254_s1", 128'(bus.synd[7:0]), 128'(8'h8E));
        chk("r254_s2", 128'(bus.synd[15:8]), 128'(8'h47));
        chk("r254_model", bus.synd, model(0));
        hs();

        for (int i = 0; i < 255; i++) sym[i] = 8'($urandom);
        send(0, 255, 40, sv);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("gap_valid", 128'(bus.synd_valid), 128'(1));
        chk("gap_model", bus.synd, model(0));
        snap = bus.synd;
        repeat (20) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
            chk("hold_ready", 128'(bus.in_ready), 128'(0));
            chk("hold_synd", bus.synd, snap);
        end
        bus.in_valid = 1'b0;
        hs();
        send(0, 255, 0, sv);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("gapfree_same", bus.synd, snap);
        hs();

        for (int i = 0; i < 255; i++) sym[i] = 8'($urandom);
        send(0, 100, 10, sv);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_synd", bus.synd, 128'(0));
        chk("midrst_valid", 128'(bus.synd_valid), 128'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 255; i++) sym[i] = 8'h00;
        send(0, 255, 20, sv);
        chk("midrst_pre", 128'(sv), 128'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("midrst_valid2", 128'(bus.synd_valid), 128'(1));
        chk("midrst_zero", bus.synd, 128'(0));
        hs();

        for (int i = 0; i < 510; i++) sym[i] = 8'($urandom);
        ea = model(0);
        eb = model(255);
        bus.synd_ready = 1'b1;
        idx  = 0;
        cyc  = 0;
        nb   = 0;
        idle = 0;
        while ((idx < 510 || nb < 2) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (bus.synd_valid) begin
                chk("b2b_blk", bus.synd, (nb == 0) ? ea : eb);
                nb++;
            end
            if (!bus.in_ready && idx == 255) idle++;
            v = (idx < 510);
            bus.in_valid = v;
            bus.in_data  = v ? sym[idx] : 8'h00;
            rdy = bus.in_ready;
            @(posedge clk);
            if (v && rdy) idx++;
        end
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.synd_ready = 1'b0;
        chk("b2b_count", 128'(nb), 128'(2));
        chk("b2b_idle", 128'(idle), 128'(1));
        chk("b2b_ready", 128'(bus.in_ready), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_calc.md
RS_SYNDROME_CALC -- requirements
Module: rs_syndrome_calc

Interface
REQ-001 Parameter M, default 8: symbol width in bits; GF(2^M).
REQ-002 Parameter N, default 255: codeword length in symbols.
REQ-003 Parameter T, default 8: correctable symbols; 2T syndromes computed.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_data holds a received symbol.
REQ-007 in_ready  output  1  block accepts a symbol this cycle.
REQ-008 in_data  input  M  received symbol, highest-degree coefficient r(N-1) first.
REQ-009 synd_valid  output  1  syndrome vector complete and stable.
REQ-010 synd_ready  input  1  downstream consumes syndrome vector.
REQ-011 synd  output  2T*M  S_j at bits [j*M-1 : (j-1)*M], j=1..2T.
REQ-012 synd_nonzero  output  1  OR of all S_j != 0; present only with RS_SYND_FLAG_EN.

Function
REQ-013 Field: GF(2^M) with primitive polynomial 0x11D (M=8), alpha = 0x02; first consecutive root alpha^1.
REQ-014 S_j = r(alpha^j), j=1..2T, by Horner rule: on accept, S_j <= (S_j * alpha^j) XOR in_data.
REQ-015 Symbol accepted only when in_valid && in_ready; no accumulator or counter change otherwise.
REQ-016 One symbol accepted per cycle maximum; full throughput when in_valid held high.
REQ-017 FSM states ACCUM, DONE; reset state ACCUM.
REQ-018 ACCUM: in_ready = 1, synd_valid = 0; symbol counter increments 0..N-1 per accept.
REQ-019 Accept with counter == N-1: counter wraps to 0, FSM -> DONE next cycle.
REQ-020 Latency: synd_valid high the cycle after the N-th symbol is accepted.
REQ-021 DONE: in_ready = 0, synd_valid = 1, synd and synd_nonzero held stable until handshake.
REQ-022 synd_valid && synd_ready in DONE: all S_j cleared to 0, FSM -> ACCUM next cycle.
REQ-023 in_valid during DONE ignored; next block's first symbol accepted no earlier than cycle after handshake.
REQ-024 synd_ready ignored in ACCUM.
REQ-025 Multiply by constant alpha^j: combinational, no pipeline stages inside a Horner step.

Reset
REQ-026 rst_n low: FSM = ACCUM, counter = 0, all S_j = 0, synd_valid = 0, in_ready = 1 after release, synd_nonzero = 0.
REQ-027 Reset mid-block discards partial accumulation; next accepted symbol treated as r(N-1).
REQ-028 Reset in DONE discards pending syndromes without handshake.

Configuration
REQ-029 Macro RS_SYND_FLAG_EN defined: synd_nonzero port and its registered OR-reduction compiled in, updated with S_j, valid in DONE.
REQ-030 RS_SYND_FLAG_EN undefined: no synd_nonzero port, no reduction logic; all other behaviour identical.

Structure
REQ-031 Shared package rs_pkg: M, N, T defaults, PRIM_POLY = 0x11D, alpha-power constant table alpha^1..alpha^2T.
REQ-032 Sub-module rs_synd_cell: one Horner cell (register + constant multiply via gf_multiplier_comb + XOR), 2T instances by generate.
REQ-033 Counter width ceil(log2(N)); FSM and counter in top level only.

Verification
REQ-034 All-zero block, 255 symbols -> synd_valid at cycle 256 after first accept, all S_j = 0x00, synd_nonzero = 0.
REQ-035 Block zeros except last symbol r(0) = 0x05 -> every S_j = 0x05, synd_nonzero = 1.
REQ-036 Block zeros except first symbol r(254) = 0x01 -> S_1 = 0x8E, S_2 = 0x47.
REQ-037 Random in_valid gaps and synd_ready held low 20 cycles -> in_ready = 0, synd unchanged throughout, same syndromes as gap-free run.
REQ-038 rst_n pulsed low after 100 symbols, then all-zero block -> all S_j = 0x00 after exactly 255 further accepts.
REQ-039 Back-to-back blocks with synd_ready = 1 -> one idle input cycle between blocks, second vector independent of first.
